wb_commit_queue: RTL and testbench
==================================

// Module: wb_commit_queue
// PURPOSE
//  Writeback commit buffer feeding the dual-write-port register file. Accepts results from two
//  producers (A = ALU path, B = load path), queues them in program order and retires up to two per
//  cycle onto write ports 1/2. Merges same-register pairs, drops writes to $0, and supports hold/flush.
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >= 2
//  AW     5   register address width
//  DW     32  data width
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst_n        in   1      asynchronous active-low reset
//  a_valid      in   1      producer A result valid
//  a_reg        in   AW     producer A destination register
//  a_data       in   DW     producer A result
//  a_ready      out  1      A accepted on posedge when a_valid & a_ready
//  b_valid      in   1      producer B result valid
//  b_reg        in   AW     producer B destination register
//  b_data       in   DW     producer B result
//  b_ready      out  1      B accepted on posedge when b_valid & b_ready
//  hold         in   1      freeze retirement; enqueue continues
//  flush        in   1      discard all queued entries
//  write_reg1   out  AW     regfile write port 1 address
//  write_data1  out  DW     regfile write port 1 data
//  reg_write1   out  1      regfile write port 1 enable
//  write_reg2   out  AW     regfile write port 2 address
//  write_data2  out  DW     regfile write port 2 data
//  reg_write2   out  1      regfile write port 2 enable
//  count        out  $clog2(DEPTH)+1  registered occupancy
//  empty        out  1      count == 0
// BEHAVIOUR
//  - Reset: queue empty, count 0, all write ports (reg/data/enable) 0; a_ready/b_ready 1.
//  - Ready (from registered count only, no credit for same-cycle pops):
//    a_ready = (count <= DEPTH-1); b_ready = (count <= DEPTH-2).
//  - Order: same-cycle accepts enqueue A then B (A older). Accepts with reg == 0 are consumed but
//    never enqueued (no occupancy, never written).
//  - Write ports are registered: entry accepted at posedge k is driven at earliest from posedge
//    k+1 (written by regfile on the following negedge). Entries accepted this edge are not
//    eligible to retire on the same edge.
//  - Retire at each posedge when !hold & !flush, using head E0 and next E1:
//    count==0: both enables 0.  count==1: port1 = E0, pop 1.
//    count>=2, E0.reg != E1.reg: port1 = E0, port2 = E1, pop 2.
//    count>=2, E0.reg == E1.reg: port2 = E1 only, reg_write1 = 0, pop 2 (E0 superseded).
//  - hold=1: both enables driven 0 next cycle; queue retained; enqueue still allowed up to ready.
//  - flush=1 (takes priority over hold and enqueue): queue cleared, same-cycle accepts discarded,
//    enables 0 next cycle; ports already driven this cycle complete normally.
//  - Read/write pointers wrap modulo DEPTH; count = enqueued - retired, never exceeds DEPTH.
//  - Reset asserted mid-operation: immediate return to reset state, pending entries lost.
// CONFIGURATION
//  WBQ_BYPASS_EN defined: adds ports fwd_reg1/fwd_reg2 (in, AW), fwd_hit1/fwd_hit2 (out, 1),
//    fwd_data1/fwd_data2 (out, DW), combinational. Hit when any queued entry or currently driven
//    enabled write port targets fwd_regN; data from the youngest match. fwd_regN == 0 never hits.
//  Not defined: ports absent; no lookup logic.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> enables 0, count 0, empty 1, a_ready=b_ready=1 immediately.
//  2 A only: a_reg=5,a_data=0x11 at edge k -> edge k+1: write_reg1=5,data1=0x11,reg_write1=1,reg_write2=0.
//  3 Same cycle A(r7,0xAA), B(r7,0xBB) -> next: reg_write1=0, write_reg2=7, write_data2=0xBB, count 0.
//  4 hold=1, enqueue A r1..r4 (DEPTH=4) -> b_ready=0 at count 3, a_ready=0 at count 4;
//    release -> r1/r2 on ports 1/2, then r3/r4 next cycle, count 0.
//  5 a_reg=0 accepted -> count unchanged, no write ever; flush with 3 queued -> count 0, no writes.
//  6 WBQ_BYPASS_EN, hold=1, queued r9=0x1 then r9=0x2, fwd_reg1=9 -> fwd_hit1=1, fwd_data1=0x2.

Source files
------------

// File: rtl/wb_commit_queue.sv
// In-order writeback queue retiring up to two results per cycle to registered write ports (1 cycle min).
// Ready is derived from registered occupancy only; optional forwarding lookup under WBQ_BYPASS_EN.
module wb_commit_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       a_valid,
   input  logic [AW-1:0]              a_reg,
   input  logic [DW-1:0]              a_data,
   output logic                       a_ready,
   input  logic                       b_valid,
   input  logic [AW-1:0]              b_reg,
   input  logic [DW-1:0]              b_data,
   output logic                       b_ready,
   input  logic                       hold,
   input  logic                       flush,
   output logic [AW-1:0]              write_reg1,
   output logic [DW-1:0]              write_data1,
   output logic                       reg_write1,
   output logic [AW-1:0]              write_reg2,
   output logic [DW-1:0]              write_data2,
   output logic                       reg_write2,
`ifdef WBQ_BYPASS_EN
   input  logic [AW-1:0]              fwd_reg1,
   input  logic [AW-1:0]              fwd_reg2,
   output logic                       fwd_hit1,
   output logic                       fwd_hit2,
   output logic [DW-1:0]              fwd_data1,
   output logic [DW-1:0]              fwd_data2,
`endif
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] A_LIM = CW'(DEPTH - 1);
   localparam logic [CW-1:0] B_LIM = CW'(DEPTH - 2);

   logic [AW-1:0] q_reg  [DEPTH];
   logic [DW-1:0] q_data [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr1, b_slot;
   logic          a_push, b_push, retire, merge;
   logic [1:0]    n_push, n_pop;

   assign a_ready = (count <= A_LIM);
   assign b_ready = (count <= B_LIM);
   assign empty   = (count == '0);

   always_comb begin
      a_push  = a_valid & a_ready & (a_reg != '0) & ~flush;
      b_push  = b_valid & b_ready & (b_reg != '0) & ~flush;
      n_push  = {1'b0, a_push} + {1'b0, b_push};
      b_slot  = wr_ptr + PW'(a_push);
      rd_ptr1 = rd_ptr + PW'(1);
      retire  = ~hold & ~flush;
      merge   = (q_reg[rd_ptr] == q_reg[rd_ptr1]);
      n_pop   = 2'd0;
      if (retire) begin
         if (count == CW'(1))
            n_pop = 2'd1;
         else if (count >= CW'(2))
            n_pop = 2'd2;
      end
   end

   // Storage needs no reset: occupancy alone says which slots are live.
   always_ff @(posedge clk) begin
      if (a_push) begin
         q_reg[wr_ptr]  <= a_reg;
         q_data[wr_ptr] <= a_data;
      end
      if (b_push) begin
         q_reg[b_slot]  <= b_reg;
         q_data[b_slot] <= b_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         write_reg1  <= '0;
         write_data1 <= '0;
         reg_write1  <= 1'b0;
         write_reg2  <= '0;
         write_data2 <= '0;
         reg_write2  <= 1'b0;
      end else if (flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         reg_write1 <= 1'b0;
         reg_write2 <= 1'b0;
      end else begin
         rd_ptr     <= rd_ptr + PW'(n_pop);
         wr_ptr     <= wr_ptr + PW'(n_push);
         count      <= count - CW'(n_pop) + CW'(n_push);
         reg_write1 <= 1'b0;
         reg_write2 <= 1'b0;
         if (n_pop != 2'd0 && !(n_pop == 2'd2 && merge)) begin
            write_reg1  <= q_reg[rd_ptr];
            write_data1 <= q_data[rd_ptr];
            reg_write1  <= 1'b1;
         end
         // A same-register pair retires only the younger value.
         if (n_pop == 2'd2) begin
            write_reg2  <= q_reg[rd_ptr1];
            write_data2 <= q_data[rd_ptr1];
            reg_write2  <= 1'b1;
         end
      end
   end

`ifdef WBQ_BYPASS_EN
   logic [PW-1:0] idx;

   // Scan oldest to youngest so the last match wins: port1, port2, then queue order.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      idx       = rd_ptr;
      if (reg_write1 && write_reg1 == fwd_reg1) begin fwd_hit1 = 1'b1; fwd_data1 = write_data1; end
      if (reg_write2 && write_reg2 == fwd_reg1) begin fwd_hit1 = 1'b1; fwd_data1 = write_data2; end
      if (reg_write1 && write_reg1 == fwd_reg2) begin fwd_hit2 = 1'b1; fwd_data2 = write_data1; end
      if (reg_write2 && write_reg2 == fwd_reg2) begin fwd_hit2 = 1'b1; fwd_data2 = write_data2; end
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count) begin
            idx = rd_ptr + PW'(i);
            if (q_reg[idx] == fwd_reg1) begin fwd_hit1 = 1'b1; fwd_data1 = q_data[idx]; end
            if (q_reg[idx] == fwd_reg2) begin fwd_hit2 = 1'b1; fwd_data2 = q_data[idx]; end
         end
      end
      if (fwd_reg1 == '0) begin fwd_hit1 = 1'b0; fwd_data1 = '0; end
      if (fwd_reg2 == '0) begin fwd_hit2 = 1'b0; fwd_data2 = '0; end
   end
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Randomized bench for wb_commit_queue against a queue-based reference model, plus directed literal cases.
module tb_wb_commit_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0, flush = 1'b0;
   logic [AW-1:0] a_reg = '0, b_reg = '0;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic          a_ready, b_ready, reg_write1, reg_write2, empty;
   logic [AW-1:0] write_reg1, write_reg2;
   logic [DW-1:0] write_data1, write_data2;
   logic [2:0]    count;
`ifdef WBQ_BYPASS_EN
   logic [AW-1:0] fwd_reg1 = '0, fwd_reg2 = '0;
   logic          fwd_hit1, fwd_hit2;
   logic [DW-1:0] fwd_data1, fwd_data2;
`endif

   int total = 0;
   int bad   = 0;
   bit run   = 1'b0;

   always #5 clk = ~clk;

   wb_commit_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
      .hold(hold), .flush(flush),
      .write_reg1(write_reg1), .write_data1(write_data1), .reg_write1(reg_write1),
      .write_reg2(write_reg2), .write_data2(write_data2), .reg_write2(reg_write2),
`ifdef WBQ_BYPASS_EN
      .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
      .count(count), .empty(empty)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: program-order list of pending writes and the expected port state.
   typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } ent_t;
   ent_t          mq[$];
   ent_t          e0, e1;
   bit            e_we1 = 1'b0, e_we2 = 1'b0, acc_a, acc_b;
   logic [AW-1:0] e_r1, e_r2;
   logic [DW-1:0] e_d1, e_d2;
   int            n;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         e_we1 = 1'b0;
         e_we2 = 1'b0;
      end else begin
         n     = mq.size();
         acc_a = a_valid && (n <= DEPTH - 1);
         acc_b = b_valid && (n <= DEPTH - 2);
         e_we1 = 1'b0;
         e_we2 = 1'b0;
         if (flush) begin
            mq.delete();
         end else begin
            if (!hold && n > 0) begin
               e0 = mq.pop_front();
               if (n == 1) begin
                  e_we1 = 1'b1; e_r1 = e0.r; e_d1 = e0.d;
               end else begin
                  e1 = mq.pop_front();
                  e_we2 = 1'b1; e_r2 = e1.r; e_d2 = e1.d;
                  if (e0.r != e1.r) begin
                     e_we1 = 1'b1; e_r1 = e0.r; e_d1 = e0.d;
                  end
               end
            end
            if (acc_a && a_reg != 0) mq.push_back('{a_reg, a_data});
            if (acc_b && b_reg != 0) mq.push_back('{b_reg, b_data});
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("count", 32'(count), 32'(mq.size()));
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("a_ready", 32'(a_ready), 32'(mq.size() <= DEPTH - 1));
         chk("b_ready", 32'(b_ready), 32'(mq.size() <= DEPTH - 2));
         chk("reg_write1", 32'(reg_write1), 32'(e_we1));
         chk("reg_write2", 32'(reg_write2), 32'(e_we2));
         if (e_we1) begin
            chk("write_reg1", 32'(write_reg1), 32'(e_r1));
            chk("write_data1", write_data1, e_d1);
         end
         if (e_we2) begin
            chk("write_reg2", 32'(write_reg2), 32'(e_r2));
            chk("write_data2", write_data2, e_d2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
      a_valid = v; a_reg = r; a_data = d;
   endtask

   task automatic drive_b(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
      b_valid = v; b_reg = r; b_data = d;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_a_ready"}, 32'(a_ready), 1);
      chk({tag, "_b_ready"}, 32'(b_ready), 1);
      chk({tag, "_we1"}, 32'(reg_write1), 0);
      chk({tag, "_we2"}, 32'(reg_write2), 0);
      chk({tag, "_reg1"}, 32'(write_reg1), 0);
      chk({tag, "_data1"}, write_data1, 0);
      chk({tag, "_reg2"}, 32'(write_reg2), 0);
      chk({tag, "_data2"}, write_data2, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("rst");
      rst_n = 1'b1;
      run   = 1'b1;

      // Single A result lands on port 1 one edge after acceptance.
      drive_a(1, 5, 32'h11); step(); drive_a(0, 0, 0);
      chk("a_only_count", 32'(count), 1);
      chk("a_only_we1_early", 32'(reg_write1), 0);
      step();
      chk("a_only_we1", 32'(reg_write1), 1);
      chk("a_only_reg1", 32'(write_reg1), 5);
      chk("a_only_data1", write_data1, 32'h11);
      chk("a_only_we2", 32'(reg_write2), 0);

      // Same-register pair: only the younger (B) value is written.
      drive_a(1, 7, 32'hAA); drive_b(1, 7, 32'hBB); step();
      drive_a(0, 0, 0); drive_b(0, 0, 0);
      chk("merge_count_q", 32'(count), 2);
      step();
      chk("merge_we1", 32'(reg_write1), 0);
      chk("merge_we2", 32'(reg_write2), 1);
      chk("merge_reg2", 32'(write_reg2), 7);
      chk("merge_data2", write_data2, 32'hBB);
      chk("merge_count", 32'(count), 0);

      // Fill under hold, watch ready thresholds, then drain two per cycle.
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive_a(1, AW'(i), 32'h100 + 32'(i)); step();
         chk("fill_count", 32'(count), 32'(i));
         if (i == 3) begin
            chk("fill_b_ready3", 32'(b_ready), 0);
            chk("fill_a_ready3", 32'(a_ready), 1);
         end
      end
      chk("fill_a_ready4", 32'(a_ready), 0);
      chk("fill_we_held", 32'(reg_write1 | reg_write2), 0);
      drive_a(0, 0, 0); hold = 1'b0; step();
      chk("drain1_reg1", 32'(write_reg1), 1);
      chk("drain1_reg2", 32'(write_reg2), 2);
      chk("drain1_we", 32'({reg_write1, reg_write2}), 3);
      chk("drain1_count", 32'(count), 2);
      step();
      chk("drain2_reg1", 32'(write_reg1), 3);
      chk("drain2_data2", write_data2, 32'h104);
      chk("drain2_count", 32'(count), 0);

      // Register 0 consumed without occupancy; flush discards queue and same-edge accepts.
      drive_a(1, 0, 32'h55); step(); drive_a(0, 0, 0);
      chk("r0_count", 32'(count), 0);
      step();
      chk("r0_we", 32'({reg_write1, reg_write2}), 0);
      hold = 1'b1;
      drive_a(1, 1, 32'h1); drive_b(1, 2, 32'h2); step();
      drive_a(1, 3, 32'h3); drive_b(0, 0, 0); step();
      chk("pre_flush_count", 32'(count), 3);
      drive_a(1, 4, 32'h4); flush = 1'b1; step();
      drive_a(0, 0, 0); flush = 1'b0; hold = 1'b0;
      chk("flush_count", 32'(count), 0);
      chk("flush_we", 32'({reg_write1, reg_write2}), 0);
      step();
      chk("post_flush_we", 32'({reg_write1, reg_write2}), 0);

`ifdef WBQ_BYPASS_EN
      hold = 1'b1;
      drive_a(1, 9, 32'h1); step();
      drive_a(1, 9, 32'h2); step();
      drive_a(0, 0, 0);
      fwd_reg1 = 9; fwd_reg2 = 0; #1;
      chk("fwd_hit1", 32'(fwd_hit1), 1);
      chk("fwd_data1", fwd_data1, 32'h2);
      chk("fwd_hit2_r0", 32'(fwd_hit2), 0);
      flush = 1'b1; step(); flush = 1'b0; hold = 1'b0;
`endif

      // Randomized traffic with varying hold/flush pressure and one mid-run reset.
      for (int i = 0; i < 2000; i++) begin
         int ph;
         ph = (i / 250) % 4;
         drive_a($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), $urandom);
         drive_b($urandom_range(0, 9) < (ph == 1 ? 9 : 6), AW'($urandom_range(0, 7)), $urandom);
         hold  = $urandom_range(0, 9) < (ph == 2 ? 6 : 1);
         flush = $urandom_range(0, 39) < (ph == 3 ? 3 : 1);
         step();
         if (i == 1000) begin
            #3 rst_n = 1'b0;
            #1 chk_reset_state("midrst");
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
      end
      drive_a(0, 0, 0); drive_b(0, 0, 0); hold = 1'b0; flush = 1'b0;
      repeat (4) step();
      chk("final_empty", 32'(empty), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
